// File: rtl/issue_scheduler.sv
// Dual-slot in-order issue scheduler: register scoreboard, intra-pair hazard
// detection, a run/stall/flush control FSM and a sticky stall watchdog.
module issue_scheduler #(
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid0,
    input  logic        fetch_valid1,
    input  logic [31:0] instr0,
    input  logic [31:0] instr1,
    input  logic        ack1,
    input  logic        ack2,
    input  logic        wb_valid1,
    input  logic [4:0]  wb_rd1,
    input  logic        wb_valid2,
    input  logic [4:0]  wb_rd2,
    input  logic        flush,
    output logic        pop0,
    output logic        pop1,
    output logic        iss1_valid,
    output logic [31:0] iss1_instr,
    output logic        iss2_valid,
    output logic [31:0] iss2_instr,
    output logic        freeze1,
    output logic        freeze2,
    output logic        dependency_on_ins2,
    output logic        nothing_filled,
    output logic [31:0] busy_mask,
    output logic        hang
);

    localparam int unsigned CW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STALL_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL,
        FLUSH
    } state_t;

    state_t          state;
    logic [CW-1:0]   stall_cnt;
    logic [CW-1:0]   stall_inc;

    logic [6:0] op_a, op_b;
    logic [4:0] rd_a, rs1_a, rs2_a, rd_b, rs1_b, rs2_b;
    logic       wr_a, rd1_a, rd2_a, wr_b, rd1_b, rd2_b;
    logic       conf_a, conf_b, hazard, can_b, blocked_a, issue_ok;
    logic [31:0] busy_nxt;

    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        logic w;
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: w = 1'b1;
            default:                            w = 1'b0;
        endcase
        return w && (rd != 5'd0);
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111);
    endfunction

    // Field decode, scoreboard conflicts and intra-pair hazard for both slots
    always_comb begin
        op_a  = instr0[6:0];
        rd_a  = instr0[11:7];
        rs1_a = instr0[19:15];
        rs2_a = instr0[24:20];
        op_b  = instr1[6:0];
        rd_b  = instr1[11:7];
        rs1_b = instr1[19:15];
        rs2_b = instr1[24:20];

        wr_a  = writes_rd(op_a, rd_a);
        rd1_a = reads_rs1(op_a);
        rd2_a = reads_rs2(op_a);
        wr_b  = writes_rd(op_b, rd_b);
        rd1_b = reads_rs1(op_b);
        rd2_b = reads_rs2(op_b);

        conf_a = (rd1_a && busy_mask[rs1_a]) || (rd2_a && busy_mask[rs2_a]) ||
                 (wr_a && busy_mask[rd_a]);
        conf_b = (rd1_b && busy_mask[rs1_b]) || (rd2_b && busy_mask[rs2_b]) ||
                 (wr_b && busy_mask[rd_b]);

        hazard = (wr_a && rd1_b && (rs1_b == rd_a)) ||
                 (wr_a && rd2_b && (rs2_b == rd_a)) ||
                 (wr_a && wr_b && (rd_b == rd_a)) ||
                 is_ctrl(op_a);

        can_b     = fetch_valid1 && ack2 && !conf_b;
        blocked_a = fetch_valid0 && !(ack1 && !conf_a);
        issue_ok  = rst && (state == RUN) && !flush;
        pop0      = issue_ok && fetch_valid0 && ack1 && !conf_a;
        pop1      = pop0 && can_b && !hazard;
    end

    // Scoreboard update: writeback clears first, then issue sets so a set wins
    always_comb begin
        busy_nxt = busy_mask;
        if (wb_valid1) busy_nxt[wb_rd1] = 1'b0;
        if (wb_valid2) busy_nxt[wb_rd2] = 1'b0;
        if (pop0 && wr_a) busy_nxt[rd_a] = 1'b1;
        if (pop1 && wr_b) busy_nxt[rd_b] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign stall_inc = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + 1'b1;

    // Control FSM, stall watchdog, issue registers and scoreboard state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            stall_cnt          <= '0;
            hang               <= 1'b0;
            iss1_valid         <= 1'b0;
            iss2_valid         <= 1'b0;
            iss1_instr         <= '0;
            iss2_instr         <= '0;
            freeze1            <= 1'b1;
            freeze2            <= 1'b1;
            nothing_filled     <= 1'b1;
            dependency_on_ins2 <= 1'b0;
            busy_mask          <= '0;
        end else begin
            iss1_valid         <= pop0;
            iss2_valid         <= pop1;
            freeze1            <= !pop0;
            freeze2            <= !pop1;
            nothing_filled     <= !pop0;
            dependency_on_ins2 <= pop0 && can_b && hazard;
            busy_mask          <= busy_nxt;
            if (pop0) iss1_instr <= instr0;
            if (pop1) iss2_instr <= instr1;

            stall_cnt <= '0;
            if (flush) begin
                state <= FLUSH;
            end else begin
                case (state)
                    IDLE: if (fetch_valid0) state <= RUN;
                    RUN: begin
                        if (!fetch_valid0)  state <= IDLE;
                        else if (!pop0)     state <= STALL;
                    end
                    STALL: begin
                        // Re-entering RUN costs one non-issuing cycle.
                        if (blocked_a) begin
                            stall_cnt <= stall_inc;
                            if (stall_inc == CNT_MAX) hang <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                    FLUSH: if (busy_mask == '0) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter STALL_LIMIT, default 15, consecutive blocked cycles before the sticky hang flag sets.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 fetch_valid0 / fetch_valid1  input  1 each  instruction slot 0 / slot 1 holds a valid word.
REQ-005 instr0 / instr1  input  32 each  RV32 words; instr0 is older in program order.
REQ-006 ack1 / ack2  input  1 each  execution lane 1 / lane 2 can accept an instruction this cycle.
REQ-007 wb_valid1, wb_rd1 / wb_valid2, wb_rd2  input  1, 5  lane writeback completion, clears the scoreboard bit for that register.
REQ-008 flush  input  1  discard pending issue, then drain.
REQ-009 pop0 / pop1  output  1 each  combinational; the fetch buffer consumes slot 0 / slot 1 this cycle.
REQ-010 iss1_valid, iss1_instr / iss2_valid, iss2_instr  output  1, 32  registered issue to lane 1 / lane 2.
REQ-011 freeze1 / freeze2  output  1 each  registered; equal to !iss1_valid / !iss2_valid.
REQ-012 dependency_on_ins2  output  1  registered; instr1 was held only because of an intra-pair hazard.
REQ-013 nothing_filled  output  1  registered; no issue occurred in the previous cycle.
REQ-014 busy_mask  output  32  registered scoreboard; bit 0 is always 0.
REQ-015 hang  output  1  sticky stall-watchdog flag.

Function
REQ-016 Decode fields: rd = [11:7], rs1 = [19:15], rs2 = [24:20], opcode = [6:0].
REQ-017 An instruction writes rd when its opcode is one of 0110011, 0010011, 0000011, 0110111, 0010111, 1101111 or 1100111, and rd is not 0.
REQ-018 An instruction reads rs1 unless its opcode is 0110111, 0010111 or 1101111.
REQ-019 An instruction reads rs2 only when its opcode is 0110011, 0100011 or 1100011.
REQ-020 A register read or written by an instruction is a scoreboard conflict when its busy_mask bit is set.
REQ-021 Slot A issues when the FSM is in RUN, fetch_valid0 is high, ack1 is high and A has no scoreboard conflict.
REQ-022 Slot B issues only if A issues in the same cycle, fetch_valid1 and ack2 are high, B has no scoreboard conflict, and B has no intra-pair hazard.
REQ-023 Intra-pair hazard: B reads A's rd (RAW), B writes the same rd as A (WAW), or A's opcode is 1100011, 1101111 or 1100111 (control flow).
REQ-024 B never issues without A (strict in-order); pop0 = A issues, pop1 = B issues.
REQ-025 Issue latency is one cycle: the iss*_valid/iss*_instr registers load on the cycle of pop and are otherwise valid = 0; iss*_instr holds its last value while valid = 0.
REQ-026 The scoreboard sets the rd bit of each issued writer and clears wb_rd1/wb_rd2 bits when their wb_valid is high.
REQ-027 When a set and a clear hit the same register in one cycle, the set wins; dual clears of the same register are legal.
REQ-028 dependency_on_ins2 is 1 exactly when A issued and B was valid with ack2 high, no scoreboard conflict, and an intra-pair hazard.
REQ-029 FSM states: IDLE, RUN, STALL, FLUSH.
  - IDLE -> RUN when fetch_valid0 = 1.
  - RUN -> STALL when fetch_valid0 = 1 and A is not issued.
  - RUN -> IDLE when fetch_valid0 = 0.
  - STALL -> RUN in the cycle its blocking condition clears; that cycle does not issue.
  - Any state -> FLUSH on flush = 1, with pops suppressed that cycle.
  - FLUSH -> IDLE once busy_mask == 0 and flush = 0.
REQ-030 No pops or issues occur in FLUSH; writeback clears still apply.
REQ-031 stall_cnt increments each cycle in STALL, saturates at STALL_LIMIT and clears on leaving STALL.
REQ-032 hang sets when stall_cnt reaches STALL_LIMIT and stays set until reset.
REQ-033 Writebacks to x0 are ignored.

Reset
REQ-034 On rst low, asynchronously: FSM = IDLE; iss*_valid = 0; iss*_instr = 0; freeze1 = freeze2 = 1; nothing_filled = 1; dependency_on_ins2 = 0; busy_mask = 0; stall_cnt = 0; hang = 0.
REQ-035 pop0 and pop1 are 0 while rst is low.
REQ-036 Reset asserted mid-stall or mid-flush discards all in-flight state; the first issue is possible on the second edge after rst rises.

Verification
REQ-037 Independent pair (addi x1,x0,1 ; addi x2,x0,2), ack1 = ack2 = 1 -> pop0 = pop1 = 1; the next cycle both iss valid, busy_mask = 0x6.
REQ-038 RAW pair (addi x1,x0,1 ; add x3,x1,x1) -> only pop0; the next cycle iss2_valid = 0, dependency_on_ins2 = 1.
REQ-039 busy_mask bit 5 set with instr0 = add x6,x5,x0 -> STALL; wb_valid1 = 1, wb_rd1 = 5 -> bit cleared, return to RUN, issue the following cycle.
REQ-040 Same cycle: issue writer to x7 and wb_rd2 = 7 clear -> bit 7 remains 1.
REQ-041 Hold a conflict for 15 cycles -> hang = 1 and it stays 1 after the conflict clears.
REQ-042 flush with busy_mask = 0x10 -> no pops; FLUSH persists until wb_rd1 = 4 clears the bit, then IDLE.
